// File: rtl/alu_pipe_if.sv
// Handshake bundle between operand fetch, the pipelined ALU and writeback.
// The master side drives operands/op and out_ready; the slave side is the ALU.
interface alu_pipe_if #(
   parameter int WIDTH = 8
);
   localparam int SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [SHW-1:0]   shamt;
   logic [3:0]       op;
   logic             set_flags;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [3:0]       res_nzcv;
   logic [3:0]       flags_q;

   modport master (
      output in_valid, a, b, shamt, op, set_flags, out_ready,
      input  in_ready, out_valid, result, res_nzcv, flags_q
   );

   modport slave (
      input  in_valid, a, b, shamt, op, set_flags, out_ready,
      output in_ready, out_valid, result, res_nzcv, flags_q
   );
endinterface

// File: rtl/alu_pipe.sv
// Single-stage pipelined ALU with valid/ready handshake and an NZCV flag register.
// The result register doubles as the output skid: it holds while downstream stalls.
module alu_pipe #(
   parameter int WIDTH = 8
) (
   input logic       clk,
   input logic       rst,
   alu_pipe_if.slave bus
);
   localparam logic [5:0] W6 = 6'(WIDTH);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_SHL = 4'b0100;
   localparam logic [3:0] OP_SHR = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_ASR = 4'b0111;
   localparam logic [3:0] OP_ROL = 4'b1000;
   localparam logic [3:0] OP_ROR = 4'b1001;
   localparam logic [3:0] OP_ADC = 4'b1010;
   localparam logic [3:0] OP_SBC = 4'b1011;

   logic             out_valid_reg;
   logic [WIDTH-1:0] result_reg;
   logic [3:0]       nzcv_reg;
   logic [3:0]       flags_reg;

   logic             accept;
   logic             flag_c;
   logic [WIDTH-1:0] bx;
   logic             cin;
   logic [WIDTH:0]   sum;
   logic [5:0]       amt;
   logic [5:0]       rot;
   logic [WIDTH:0]   shl_ext;
   logic [WIDTH:0]   shr_ext;
   logic [WIDTH:0]   asr_ext;
   logic [WIDTH-1:0] rol_val;
   logic [WIDTH-1:0] ror_val;
   logic             shift_op;
   logic [WIDTH-1:0] result_next;
   logic             c_next;
   logic             v_next;
   logic [3:0]       nzcv_next;

   assign flag_c       = flags_reg[1];
   assign bus.in_ready = !out_valid_reg || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      bx          = bus.b;
      cin         = 1'b0;
      amt         = 6'(bus.shamt);
      rot         = amt % W6;
      shift_op    = 1'b0;
      result_next = '0;
      c_next      = 1'b0;
      v_next      = 1'b0;

      // One adder serves ADD/SUB/ADC/SBC: op[0] inverts B, op[3] selects carry-in source.
      if (bus.op == OP_SUB || bus.op == OP_SBC) begin
         bx = ~bus.b;
      end
      if (bus.op[3]) begin
         cin = flag_c;
      end else begin
         cin = bus.op[0];
      end
      sum = {1'b0, bus.a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};

      // Extended vectors keep the last bit shifted out; amounts past WIDTH fall out naturally.
      shl_ext = {1'b0, bus.a} << amt;
      shr_ext = {bus.a, 1'b0} >> amt;
      asr_ext = $signed({bus.a, 1'b0}) >>> amt;
      rol_val = (bus.a << rot) | (bus.a >> (W6 - rot));
      ror_val = (bus.a >> rot) | (bus.a << (W6 - rot));

      case (bus.op)
         OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
            result_next = sum[WIDTH-1:0];
            c_next      = sum[WIDTH];
            v_next      = (bus.a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_AND: begin
            result_next = bus.a & bus.b;
            c_next      = flag_c;
         end
         OP_OR: begin
            result_next = bus.a | bus.b;
            c_next      = flag_c;
         end
         OP_XOR: begin
            result_next = bus.a ^ bus.b;
            c_next      = flag_c;
         end
         OP_SHL: begin
            shift_op    = 1'b1;
            result_next = shl_ext[WIDTH-1:0];
            c_next      = shl_ext[WIDTH];
         end
         OP_SHR: begin
            shift_op    = 1'b1;
            result_next = shr_ext[WIDTH:1];
            c_next      = shr_ext[0];
         end
         OP_ASR: begin
            shift_op    = 1'b1;
            result_next = asr_ext[WIDTH:1];
            c_next      = asr_ext[0];
         end
         OP_ROL: begin
            shift_op    = 1'b1;
            result_next = rol_val;
            c_next      = rol_val[0];
         end
         OP_ROR: begin
            shift_op    = 1'b1;
            result_next = ror_val;
            c_next      = ror_val[WIDTH-1];
         end
         default: begin
            result_next = '0;
            c_next      = 1'b0;
         end
      endcase

      if (shift_op && amt == 6'd0) begin
         result_next = bus.a;
         c_next      = flag_c;
      end

      nzcv_next = {result_next[WIDTH-1], (result_next == '0), c_next, v_next};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         result_reg    <= '0;
         nzcv_reg      <= '0;
         flags_reg     <= '0;
      end else if (accept) begin
         out_valid_reg <= 1'b1;
         result_reg    <= result_next;
         nzcv_reg      <= nzcv_next;
         if (bus.set_flags) begin
            flags_reg <= nzcv_next;
         end
      end else if (bus.out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign bus.out_valid = out_valid_reg;
   assign bus.result    = result_reg;
   assign bus.res_nzcv  = nzcv_reg;
   assign bus.flags_q   = flags_reg;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: 8-bit instance for function/handshake, 16-bit for width regression.
module tb_alu_pipe;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   fails  = 0;

   always #5 clk = ~clk;

   alu_pipe_if #(.WIDTH(8))  bus8 ();
   alu_pipe_if #(.WIDTH(16)) bus16 ();

   alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
   alu_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] sh, input logic sf);
      bus8.op        = op;
      bus8.a         = a;
      bus8.b         = b;
      bus8.shamt     = sh;
      bus8.set_flags = sf;
      bus8.in_valid  = 1'b1;
   endtask

   task automatic test_reset();
      rst             = 1'b1;
      bus8.in_valid   = 1'b0;
      bus8.out_ready  = 1'b1;
      bus8.op         = 4'h0;
      bus8.a          = 8'h00;
      bus8.b          = 8'h00;
      bus8.shamt      = 3'd0;
      bus8.set_flags  = 1'b0;
      bus16.in_valid  = 1'b0;
      bus16.out_ready = 1'b1;
      bus16.op        = 4'h0;
      bus16.a         = 16'h0;
      bus16.b         = 16'h0;
      bus16.shamt     = 4'd0;
      bus16.set_flags = 1'b0;
      tick();
      tick();
      checks++;
      if (bus8.out_valid !== 1'b0 || bus8.result !== 8'h00 || bus8.res_nzcv !== 4'b0000 || bus8.flags_q !== 4'b0000) begin
         fails++;
         $display("FAIL reset_state: valid=%b result=%h nzcv=%b flags=%b, want 0 00 0000 0000",
                  bus8.out_valid, bus8.result, bus8.res_nzcv, bus8.flags_q);
      end
      checks++;
      if (bus8.in_ready !== 1'b1 || bus16.out_valid !== 1'b0 || bus16.flags_q !== 4'b0000) begin
         fails++;
         $display("FAIL reset_ready: in_ready=%b v16=%b f16=%b, want 1 0 0000",
                  bus8.in_ready, bus16.out_valid, bus16.flags_q);
      end
      rst = 1'b0;
      tick();
      $display("txn reset: done");
   endtask

   task automatic test_add_sub();
      drive(4'b0000, 8'h7F, 8'h01, 3'd0, 1'b1);
      tick();
      bus8.in_valid = 1'b0;
      $display("txn ADD 7f+01: result=%h nzcv=%b flags=%b", bus8.result, bus8.res_nzcv, bus8.flags_q);
      checks++;
      if (bus8.out_valid !== 1'b1 || bus8.result !== 8'h80 || bus8.res_nzcv !== 4'b1001 || bus8.flags_q !== 4'b1001) begin
         fails++;
         $display("FAIL add_ovf: valid=%b result=%h nzcv=%b flags=%b, want 1 80 1001 1001",
                  bus8.out_valid, bus8.result, bus8.res_nzcv, bus8.flags_q);
      end
      drive(4'b0001, 8'h05, 8'h05, 3'd0, 1'b0);
      tick();
      bus8.in_valid = 1'b0;
      $display("txn SUB 05-05: result=%h nzcv=%b flags=%b", bus8.result, bus8.res_nzcv, bus8.flags_q);
      checks++;
      if (bus8.result !== 8'h00 || bus8.res_nzcv !== 4'b0110 || bus8.flags_q !== 4'b1001) begin
         fails++;
         $display("FAIL sub_zero_noflags: result=%h nzcv=%b flags=%b, want 00 0110 1001",
                  bus8.result, bus8.res_nzcv, bus8.flags_q);
      end
      drive(4'b0001, 8'h03, 8'h05, 3'd0, 1'b1);
      tick();
      bus8.in_valid = 1'b0;
      $display("txn SUB 03-05: result=%h nzcv=%b flags=%b", bus8.result, bus8.res_nzcv, bus8.flags_q);
      checks++;
      if (bus8.result !== 8'hFE || bus8.res_nzcv !== 4'b1000 || bus8.flags_q !== 4'b1000) begin
         fails++;
         $display("FAIL sub_borrow: result=%h nzcv=%b flags=%b, want fe 1000 1000",
                  bus8.result, bus8.res_nzcv, bus8.flags_q);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      drive(4'b0000, 8'hFF, 8'h01, 3'd0, 1'b1);
      tick();
      $display("txn ADD ff+01: result=%h nzcv=%b", bus8.result, bus8.res_nzcv);
      checks++;
      if (bus8.result !== 8'h00 || bus8.res_nzcv !== 4'b0110 || bus8.flags_q !== 4'b0110) begin
         fails++;
         $display("FAIL chain_add: result=%h nzcv=%b flags=%b, want 00 0110 0110",
                  bus8.result, bus8.res_nzcv, bus8.flags_q);
      end
      drive(4'b1010, 8'h00, 8'h00, 3'd0, 1'b1);
      tick();
      $display("txn ADC 00+00+C: result=%h nzcv=%b", bus8.result, bus8.res_nzcv);
      checks++;
      if (bus8.out_valid !== 1'b1 || bus8.result !== 8'h01 || bus8.flags_q !== 4'b0000) begin
         fails++;
         $display("FAIL chain_adc: valid=%b result=%h flags=%b, want 1 01 0000",
                  bus8.out_valid, bus8.result, bus8.flags_q);
      end
      drive(4'b1011, 8'h10, 8'h01, 3'd0, 1'b1);
      tick();
      bus8.in_valid = 1'b0;
      $display("txn SBC 10-01 C=0: result=%h nzcv=%b", bus8.result, bus8.res_nzcv);
      checks++;
      if (bus8.result !== 8'h0E || bus8.res_nzcv !== 4'b0010 || bus8.flags_q !== 4'b0010) begin
         fails++;
         $display("FAIL chain_sbc: result=%h nzcv=%b flags=%b, want 0e 0010 0010",
                  bus8.result, bus8.res_nzcv, bus8.flags_q);
      end
      tick();
      checks++;
      if (bus8.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL drain_valid: out_valid=%b, want 0", bus8.out_valid);
      end
   endtask

   task automatic test_shift();
      drive(4'b0100, 8'h81, 8'h00, 3'd1, 1'b1);
      tick();
      bus8.in_valid = 1'b0;
      $display("txn SHL 81<<1: result=%h nzcv=%b", bus8.result, bus8.res_nzcv);
      checks++;
      if (bus8.result !== 8'h02 || bus8.res_nzcv !== 4'b0010) begin
         fails++;
         $display("FAIL shl: result=%h nzcv=%b, want 02 0010", bus8.result, bus8.res_nzcv);
      end
      drive(4'b1000, 8'h81, 8'h00, 3'd1, 1'b0);
      tick();
      bus8.in_valid = 1'b0;
      $display("txn ROL 81 by 1: result=%h nzcv=%b", bus8.result, bus8.res_nzcv);
      checks++;
      if (bus8.result !== 8'h03 || bus8.res_nzcv !== 4'b0010) begin
         fails++;
         $display("FAIL rol: result=%h nzcv=%b, want 03 0010", bus8.result, bus8.res_nzcv);
      end
      drive(4'b1001, 8'h01, 8'h00, 3'd1, 1'b0);
      tick();
      bus8.in_valid = 1'b0;
      $display("txn ROR 01 by 1: result=%h nzcv=%b", bus8.result, bus8.res_nzcv);
      checks++;
      if (bus8.result !== 8'h80 || bus8.res_nzcv !== 4'b1010) begin
         fails++;
         $display("FAIL ror: result=%h nzcv=%b, want 80 1010", bus8.result, bus8.res_nzcv);
      end
      drive(4'b0111, 8'h80, 8'h00, 3'd3, 1'b0);
      tick();
      bus8.in_valid = 1'b0;
      $display("txn ASR 80>>>3: result=%h nzcv=%b", bus8.result, bus8.res_nzcv);
      checks++;
      if (bus8.result !== 8'hF0 || bus8.res_nzcv !== 4'b1000) begin
         fails++;
         $display("FAIL asr: result=%h nzcv=%b, want f0 1000", bus8.result, bus8.res_nzcv);
      end
      drive(4'b0101, 8'h80, 8'h00, 3'd0, 1'b0);
      tick();
      bus8.in_valid = 1'b0;
      $display("txn SHR 80 by 0: result=%h nzcv=%b", bus8.result, bus8.res_nzcv);
      checks++;
      if (bus8.result !== 8'h80 || bus8.res_nzcv !== 4'b1010 || bus8.flags_q !== 4'b0010) begin
         fails++;
         $display("FAIL shr_zero: result=%h nzcv=%b flags=%b, want 80 1010 0010",
                  bus8.result, bus8.res_nzcv, bus8.flags_q);
      end
      drive(4'b0101, 8'h46, 8'h00, 3'd2, 1'b0);
      tick();
      bus8.in_valid = 1'b0;
      $display("txn SHR 46>>2: result=%h nzcv=%b", bus8.result, bus8.res_nzcv);
      checks++;
      if (bus8.result !== 8'h11 || bus8.res_nzcv !== 4'b0010) begin
         fails++;
         $display("FAIL shr: result=%h nzcv=%b, want 11 0010", bus8.result, bus8.res_nzcv);
      end
      tick();
   endtask

   task automatic test_logic();
      drive(4'b0010, 8'hF0, 8'h3C, 3'd0, 1'b0);
      tick();
      bus8.in_valid = 1'b0;
      $display("txn AND f0&3c: result=%h nzcv=%b", bus8.result, bus8.res_nzcv);
      checks++;
      if (bus8.result !== 8'h30 || bus8.res_nzcv !== 4'b0010) begin
         fails++;
         $display("FAIL and: result=%h nzcv=%b, want 30 0010", bus8.result, bus8.res_nzcv);
      end
      drive(4'b0110, 8'h5A, 8'h5A, 3'd0, 1'b0);
      tick();
      bus8.in_valid = 1'b0;
      $display("txn XOR 5a^5a: result=%h nzcv=%b", bus8.result, bus8.res_nzcv);
      checks++;
      if (bus8.result !== 8'h00 || bus8.res_nzcv !== 4'b0110) begin
         fails++;
         $display("FAIL xor: result=%h nzcv=%b, want 00 0110", bus8.result, bus8.res_nzcv);
      end
      drive(4'b0011, 8'h80, 8'h01, 3'd0, 1'b0);
      tick();
      bus8.in_valid = 1'b0;
      $display("txn OR 80|01: result=%h nzcv=%b", bus8.result, bus8.res_nzcv);
      checks++;
      if (bus8.result !== 8'h81 || bus8.res_nzcv !== 4'b1010) begin
         fails++;
         $display("FAIL or: result=%h nzcv=%b, want 81 1010", bus8.result, bus8.res_nzcv);
      end
      drive(4'b1100, 8'hFF, 8'hFF, 3'd0, 1'b1);
      tick();
      bus8.in_valid = 1'b0;
      $display("txn RSV op c: result=%h nzcv=%b", bus8.result, bus8.res_nzcv);
      checks++;
      if (bus8.result !== 8'h00 || bus8.res_nzcv !== 4'b0100 || bus8.flags_q !== 4'b0100) begin
         fails++;
         $display("FAIL reserved: result=%h nzcv=%b flags=%b, want 00 0100 0100",
                  bus8.result, bus8.res_nzcv, bus8.flags_q);
      end
      tick();
   endtask

   task automatic test_backpressure();
      bus8.out_ready = 1'b0;
      drive(4'b0001, 8'h05, 8'h05, 3'd0, 1'b1);
      tick();
      $display("txn BP op1 SUB 05-05: result=%h in_ready=%b", bus8.result, bus8.in_ready);
      checks++;
      if (bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0 || bus8.result !== 8'h00 || bus8.flags_q !== 4'b0110) begin
         fails++;
         $display("FAIL bp_first: valid=%b in_ready=%b result=%h flags=%b, want 1 0 00 0110",
                  bus8.out_valid, bus8.in_ready, bus8.result, bus8.flags_q);
      end
      drive(4'b0000, 8'h7F, 8'h01, 3'd0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0 || bus8.result !== 8'h00 ||
             bus8.res_nzcv !== 4'b0110 || bus8.flags_q !== 4'b0110) begin
            fails++;
            $display("FAIL bp_hold%0d: valid=%b in_ready=%b result=%h nzcv=%b flags=%b, want 1 0 00 0110 0110",
                     i, bus8.out_valid, bus8.in_ready, bus8.result, bus8.res_nzcv, bus8.flags_q);
         end
      end
      bus8.out_ready = 1'b1;
      #1;
      checks++;
      if (bus8.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL bp_ready_comb: in_ready=%b, want 1", bus8.in_ready);
      end
      tick();
      bus8.in_valid = 1'b0;
      $display("txn BP op2 ADD 7f+01: result=%h flags=%b", bus8.result, bus8.flags_q);
      checks++;
      if (bus8.out_valid !== 1'b1 || bus8.result !== 8'h80 || bus8.flags_q !== 4'b1001) begin
         fails++;
         $display("FAIL bp_second: valid=%b result=%h flags=%b, want 1 80 1001",
                  bus8.out_valid, bus8.result, bus8.flags_q);
      end
      tick();
      checks++;
      if (bus8.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL bp_drain: out_valid=%b, want 0", bus8.out_valid);
      end
   endtask

   task automatic test_reset_mid();
      bus8.out_ready = 1'b0;
      drive(4'b0000, 8'h7F, 8'h01, 3'd0, 1'b1);
      tick();
      bus8.in_valid = 1'b0;
      checks++;
      if (bus8.out_valid !== 1'b1 || bus8.result !== 8'h80) begin
         fails++;
         $display("FAIL rstmid_pre: valid=%b result=%h, want 1 80", bus8.out_valid, bus8.result);
      end
      #2;
      rst = 1'b1;
      #1;
      $display("txn async reset mid-hold: valid=%b result=%h flags=%b", bus8.out_valid, bus8.result, bus8.flags_q);
      checks++;
      if (bus8.out_valid !== 1'b0 || bus8.result !== 8'h00 || bus8.res_nzcv !== 4'b0000 || bus8.flags_q !== 4'b0000) begin
         fails++;
         $display("FAIL rstmid_async: valid=%b result=%h nzcv=%b flags=%b, want 0 00 0000 0000",
                  bus8.out_valid, bus8.result, bus8.res_nzcv, bus8.flags_q);
      end
      tick();
      rst = 1'b0;
      bus8.out_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (bus8.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_quiet: out_valid=%b, want 0", bus8.out_valid);
      end
   endtask

   task automatic test_width16();
      bus16.op        = 4'b0000;
      bus16.a         = 16'hFFFF;
      bus16.b         = 16'h0001;
      bus16.shamt     = 4'd0;
      bus16.set_flags = 1'b1;
      bus16.in_valid  = 1'b1;
      tick();
      bus16.in_valid = 1'b0;
      $display("txn W16 ADD ffff+0001: result=%h nzcv=%b", bus16.result, bus16.res_nzcv);
      checks++;
      if (bus16.out_valid !== 1'b1 || bus16.result !== 16'h0000 || bus16.res_nzcv !== 4'b0110 || bus16.flags_q !== 4'b0110) begin
         fails++;
         $display("FAIL w16_add: valid=%b result=%h nzcv=%b flags=%b, want 1 0000 0110 0110",
                  bus16.out_valid, bus16.result, bus16.res_nzcv, bus16.flags_q);
      end
      bus16.op    = 4'b0111;
      bus16.a     = 16'h8001;
      bus16.shamt = 4'd15;
      bus16.set_flags = 1'b0;
      bus16.in_valid  = 1'b1;
      tick();
      bus16.in_valid = 1'b0;
      $display("txn W16 ASR 8001>>>15: result=%h nzcv=%b", bus16.result, bus16.res_nzcv);
      checks++;
      if (bus16.result !== 16'hFFFF || bus16.res_nzcv !== 4'b1000) begin
         fails++;
         $display("FAIL w16_asr: result=%h nzcv=%b, want ffff 1000", bus16.result, bus16.res_nzcv);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_back_to_back();
      test_shift();
      test_logic();
      test_backpressure();
      test_reset_mid();
      test_width16();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, single-stage pipelined ALU. It is the successor of the 8-bit combinational ALU in the datapath.
- Generalised to WIDTH bits, with a valid/ready handshake on input and output.
- Adds XOR, arithmetic shift, rotates and carry-chained ADC/SBC.
- Keeps an architectural NZCV flag register, updated under set_flags control.
- Sits between the operand-fetch stage and writeback.

Parameters:
WIDTH, 8, operand/result width; legal values 4..32.
SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand/op presented
in_ready  out  1  block can accept
a  in  WIDTH  operand A
b  in  WIDTH  operand B
shamt  in  SHW  shift/rotate amount
op  in  4  operation code
set_flags  in  1  update flag register on accept
out_valid  out  1  result held
out_ready  in  1  downstream accepts
result  out  WIDTH  registered result
res_nzcv  out  4  flags of this result {N,Z,C,V}
flags_q  out  4  architectural flag register {N,Z,C,V}

Behaviour:
- Reset (async, rst=1): out_valid=0, result=0, res_nzcv=0, flags_q=0. Reset mid-transaction discards the held result. No output is produced after reset is released until a new accept.
- Accept: fires on the rising edge when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This gives full throughput, one op per cycle under continuous out_ready.
- Latency: one cycle. Accept at edge k gives out_valid=1 with result after edge k.
- Hold: result/res_nzcv stay stable while out_valid && !out_ready.
- out_valid clears on a handshake with no simultaneous accept. Simultaneous output handshake and new accept loads the new result; out_valid stays 1.
- Opcodes:
  - 0000 ADD: A+B.
  - 0001 SUB: A-B, computed as A+~B+1.
  - 0010 AND.
  - 0011 OR.
  - 0100 SHL: logical left by shamt.
  - 0101 SHR: logical right.
  - 0110 XOR.
  - 0111 ASR: arithmetic right, sign-filled.
  - 1000 ROL: rotate left.
  - 1001 ROR: rotate right.
  - 1010 ADC: A+B+flags_q.C.
  - 1011 SBC: A+~B+flags_q.C.
  - 1100-1111: result 0, C=0, V=0.
- Flags, all ops:
  - Z = (result==0).
  - N = result[WIDTH-1].
- C, arithmetic ops: carry out of bit WIDTH-1. For SUB/SBC, C=1 means no borrow.
- V, arithmetic ops: signed overflow, computed as (opA sign == effective-B sign) && (result sign != opA sign). Effective B is ~B for SUB/SBC.
- Logic ops: C=flags_q.C (unchanged), V=0.
- Shifts/rotates:
  - shamt=0: result=A, C=flags_q.C.
  - shamt≠0: C = last bit shifted or rotated out. For SHL this is A[WIDTH-shamt]; for SHR/ASR it is A[shamt-1]. For ROL it is result[0]; for ROR it is result[WIDTH-1].
  - V=0 for all shift and rotate ops.
  - SHW bits cover 0..WIDTH-1 when WIDTH is a power of two. Otherwise an amount ≥WIDTH gives: SHL/SHR → 0; ASR → all sign bits; rotates reduce modulo WIDTH.
- Flag register:
  - On accept with set_flags=1, flags_q ← res_nzcv of that op, in the same edge that loads result.
  - set_flags=0 leaves flags_q unchanged; res_nzcv is still produced.
  - ADC/SBC read the flags_q value present at their own accept edge. Back-to-back chained ops therefore see the previous op's carry with no bubble.
  - flags_q updates only on accept, never on a stall.

Test Plan:
- WIDTH=8, ADD a=0x7F b=0x01 set_flags=1 → result=0x80, res_nzcv=1001, flags_q=1001 one cycle after accept.
- SUB a=0x05 b=0x05 → result=0x00, nzcv=0110. SUB a=0x03 b=0x05 → result=0xFE, nzcv=1000.
- Carry chain: ADD 0xFF+0x01 (set_flags) → 0x00, C=1. Next-cycle ADC 0x00+0x00 → 0x01. SBC 0x10-0x01 with C=0 → 0x0E.
- Shifts:
  - SHL 0x81 shamt=1 → 0x02, C=1.
  - ROR 0x01 shamt=1 → 0x80, C=1.
  - ASR 0x80 shamt=3 → 0xF0.
  - SHR 0x80 shamt=0 with flags_q.C=1 → 0x80, C=1.
- Backpressure: two ops issued; out_ready low 3 cycles → in_ready=0 after the first result, first result held stable, second accepted only on the handshake edge; flags_q reflects op1 only until op2 accepted.
- Reset: assert rst while out_valid=1 and out_ready=0 → out_valid, result, flags_q go to 0 immediately (asynchronous). WIDTH=16 regression: ADD 0xFFFF+0x0001 → 0x0000, nzcv=0110.
